// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request scheduler slice.
package cordic_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam logic [7:0]  X_INIT_DEF  = 8'h4B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } sched_state_e;

  // Watchdog counter width; a timeout of 1 still needs one bit.
  function automatic int unsigned wdog_cnt_w(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/cordic_req_scheduler_if.sv
// Requester-side and CORDIC-side signals of the scheduler bundled as one interface.
interface cordic_req_scheduler_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_angle_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_cos_o;
  logic [DATA_W-1:0]         rsp_sin_o;
  logic                      rsp_err_o;
  logic                      busy_o;
  logic                      timeout_o;
  logic [DATA_W-1:0]         cordic_x_o;
  logic [DATA_W-1:0]         cordic_y_o;
  logic [DATA_W-1:0]         cordic_z_o;
  logic                      cordic_start_o;
  logic [DATA_W-1:0]         cordic_x_i;
  logic [DATA_W-1:0]         cordic_y_i;
  logic                      cordic_valid_i;

  modport master (
    output req_valid_i, req_angle_i, cordic_x_i, cordic_y_i, cordic_valid_i,
    input  req_ready_o, rsp_valid_o, rsp_cos_o, rsp_sin_o, rsp_err_o,
    input  busy_o, timeout_o, cordic_x_o, cordic_y_o, cordic_z_o, cordic_start_o
  );

  modport slave (
    input  req_valid_i, req_angle_i, cordic_x_i, cordic_y_i, cordic_valid_i,
    output req_ready_o, rsp_valid_o, rsp_cos_o, rsp_sin_o, rsp_err_o,
    output busy_o, timeout_o, cordic_x_o, cordic_y_o, cordic_z_o, cordic_start_o
  );

endinterface

// File: rtl/cordic_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 with wrap and
// returns the first requester found as one-hot and binary index.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin : arb
    int unsigned k;
    k           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = 32'(last_grant) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!grant_valid && req[IDX_W'(k)]) begin
        grant_valid           = 1'b1;
        grant_idx             = IDX_W'(k);
        grant[IDX_W'(k)]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Shares one iterative CORDIC between NUM_REQ angle requesters: round-robin
// accept, single job in flight, watchdog-protected wait, one-hot response.
module cordic_req_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned       NUM_REQ = 2,
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] X_INIT  = DATA_W'(X_INIT_DEF),
  parameter int unsigned       TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cordic_req_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = wdog_cnt_w(TIMEOUT);

  sched_state_e        state,      state_n;
  logic [IDX_W-1:0]    last_grant, last_grant_n;
  logic [IDX_W-1:0]    owner,      owner_n;
  logic [DATA_W-1:0]   z_q,        z_n;
  logic [CNT_W-1:0]    cnt,        cnt_n;
  logic [DATA_W-1:0]   cos_q,      cos_n;
  logic [DATA_W-1:0]   sin_q,      sin_n;
  logic                err_q,      err_n;
  logic [NUM_REQ-1:0]  rsp_vld_q,  rsp_vld_n;
  logic                start_q,    start_n;
  logic                busy_q,     busy_n;
  logic                tmo_q,      tmo_n;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [DATA_W-1:0]   angle [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_angle
    assign angle[k] = bus.req_angle_i[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (bus.req_valid_i),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      z_q        <= '0;
      cnt        <= '0;
      cos_q      <= '0;
      sin_q      <= '0;
      err_q      <= 1'b0;
      rsp_vld_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      owner      <= owner_n;
      z_q        <= z_n;
      cnt        <= cnt_n;
      cos_q      <= cos_n;
      sin_q      <= sin_n;
      err_q      <= err_n;
      rsp_vld_q  <= rsp_vld_n;
      start_q    <= start_n;
      busy_q     <= busy_n;
      tmo_q      <= tmo_n;
    end
  end

  // Next-state and registered-output logic; strobes default low every cycle.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    owner_n      = owner;
    z_n          = z_q;
    cnt_n        = cnt;
    cos_n        = cos_q;
    sin_n        = sin_q;
    err_n        = err_q;
    tmo_n        = tmo_q;
    rsp_vld_n    = '0;
    start_n      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          z_n     = angle[arb_idx];
          owner_n = arb_idx;
          start_n = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_n   = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // A result on the last watchdog cycle still counts as a good result.
        if (bus.cordic_valid_i) begin
          cos_n            = bus.cordic_x_i;
          sin_n            = bus.cordic_y_i;
          err_n            = 1'b0;
          rsp_vld_n[owner] = 1'b1;
          state_n          = ST_RESPOND;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_n            = 1'b1;
          tmo_n            = 1'b1;
          rsp_vld_n[owner] = 1'b1;
          state_n          = ST_RESPOND;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        last_grant_n = owner;
        state_n      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  assign bus.req_ready_o    = (state == ST_IDLE) ? arb_grant : '0;
  assign bus.rsp_valid_o    = rsp_vld_q;
  assign bus.rsp_cos_o      = cos_q;
  assign bus.rsp_sin_o      = sin_q;
  assign bus.rsp_err_o      = err_q;
  assign bus.busy_o         = busy_q;
  assign bus.timeout_o      = tmo_q;
  assign bus.cordic_x_o     = X_INIT;
  assign bus.cordic_y_o     = '0;
  assign bus.cordic_z_o     = z_q;
  assign bus.cordic_start_o = start_q;

endmodule

// File: doc/cordic_req_scheduler.md
Name: cordic_req_scheduler

Overview:
Round-robin scheduler that shares one cordic_iterative instance between NUM_REQ independent angle requesters. It accepts one angle at a time and drives the CORDIC inputs and start strobe. It waits for the CORDIC done strobe with a watchdog, then returns cos/sin to the requester that owns the job. It sits between the tile's I/O decode logic and cordic_iterative.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 8, angle/result width (two's complement)
X_INIT, 8'h4B, gain-compensated start vector x driven to CORDIC (y is always 0)
TIMEOUT, 15, max cycles in WAIT before the job is aborted (must be > CORDIC latency)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-low reset
req_valid_i  in  NUM_REQ  per-requester angle valid
req_angle_i  in  NUM_REQ*DATA_W  packed angles; requester k at [k*DATA_W +: DATA_W]
req_ready_o  out  NUM_REQ  one-hot accept pulse
rsp_valid_o  out  NUM_REQ  one-hot, one-cycle result pulse
rsp_cos_o  out  DATA_W  result cos (held until next response)
rsp_sin_o  out  DATA_W  result sin (held until next response)
rsp_err_o  out  1  qualifies rsp_valid_o: job aborted by watchdog, data invalid
busy_o  out  1  high in any state except IDLE
timeout_o  out  1  sticky watchdog flag, cleared only by reset
cordic_x_o  out  DATA_W  constant X_INIT
cordic_y_o  out  DATA_W  constant 0
cordic_z_o  out  DATA_W  latched angle of current job
cordic_start_o  out  1  one-cycle data_in_valid strobe to CORDIC
cordic_x_i  in  DATA_W  CORDIC x result (cos)
cordic_y_i  in  DATA_W  CORDIC y result (sin)
cordic_valid_i  in  1  CORDIC data_out_valid strobe

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESPOND. One job in flight, no queueing.
- Reset (rst_i=0 at an edge):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 has priority first.
  - All outputs 0, except cordic_x_o=X_INIT.
  - timeout_o cleared; watchdog counter=0.
  - Reset mid-job abandons the job with no response. A CORDIC strobe that arrives later lands in IDLE and is ignored.
- IDLE:
  - If any req_valid_i is set, grant g = first set bit searching from last_grant+1 with wrap.
  - req_ready_o[g] is combinational and high only in this cycle; the handshake completes on valid&ready.
  - Register z=req_angle_i[g] and owner=g; go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE: cordic_start_o=1 for exactly one cycle, cordic_z_o stable, counter cleared; go to WAIT.
- WAIT:
  - If cordic_valid_i=1: capture cordic_x_i into rsp_cos_o and cordic_y_i into rsp_sin_o, rsp_err_o=0; go to RESPOND.
  - Otherwise increment counter. At counter==TIMEOUT-1 with no valid: set timeout_o, rsp_err_o=1, leave data unchanged; go to RESPOND.
  - Valid arriving in the same cycle as the timeout boundary: valid wins, no error.
- RESPOND: rsp_valid_o[owner]=1 for one cycle; last_grant=owner; go to IDLE.
- A new grant is possible in the cycle after RESPOND, so max throughput is one job per (CORDIC latency + 3) cycles.
- cordic_valid_i outside WAIT is ignored and does not change outputs.
- Fairness: a requester that holds valid continuously is served at least once every NUM_REQ jobs.
- cordic_z_o holds the last job angle while IDLE.
- req_valid_i deasserted before ready: no grant, no state change.

Decomposition:
- Shared package cordic_pkg:
  - FSM state enum.
  - DATA_W default and X_INIT constant.
  - Watchdog counter width = $clog2(TIMEOUT).
- Sub-module rr_arbiter: combinational round-robin over NUM_REQ with last_grant input. Outputs a one-hot grant and a binary index. Reused by later multi-client blocks.

Test Plan:
1. Bench CORDIC stub returns x=z, y=~z 9 cycles after start. Req0 angle 8'h20 -> ready0 pulse at T0, start at T0+1, rsp_valid_o[0] with cos=8'h20, sin=8'hDF at T0+11, rsp_err_o=0.
2. req_valid_i=2'b11 held constant, angles 8'h10/8'h40 -> grants alternate 0,1,0,1 over 4 jobs, each returns its own angle, never a double grant.
3. Stub never responds -> after TIMEOUT cycles in WAIT: rsp_valid_o[g]=1, rsp_err_o=1, timeout_o=1 sticky. The next job then completes normally with timeout_o still 1.
4. Stub fires cordic_valid_i exactly at counter==TIMEOUT-1 -> normal response, rsp_err_o=0, timeout_o=0.
5. rst_i=0 during WAIT, late stub strobe arrives after reset -> no rsp_valid_o, all outputs at reset values, next request granted to req0 first.
6. Spurious cordic_valid_i pulses in IDLE and ISSUE -> rsp_cos_o/rsp_sin_o unchanged, no rsp_valid_o.
